// File: rtl/period_framer_pkg.sv
// Shared definitions for the waveform-identification front end: framer
// state encoding and the default counter/window limits, which the
// downstream distinguish counter also uses for its own window checks.
package framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_LOCKED = 2'd2
    } framer_state_e;

    localparam int FRAMER_CNT_W       = 12;
    localparam int FRAMER_PER_MIN     = 200;
    localparam int FRAMER_PER_MAX     = 2000;
    localparam int FRAMER_SYNC_STAGES = 2;
    localparam int FRAMER_FILT_LEN    = 4;
    localparam int FRAMER_LOCK_N      = 2;

    // Pin-to-strobe latency of the conditioning path, identical for zc and cmp1.
    function automatic int framer_latency(input int sync_stages, input int filt_len);
        return sync_stages + filt_len + 1;
    endfunction

endpackage

// File: rtl/period_framer_if.sv
// Signal bundle between the comparator front end and the framer.
// The master side drives the two raw comparator levels; the slave side
// (the framer) returns the strobes, counters and status.
// Strobe semantics: set and cmp1_pulse are registered, high for exactly
// one clk cycle per event, and carry no back-pressure; the consumer must
// take them in the cycle they appear. phase_cnt and period are valid
// every cycle and period changes only in a set cycle.
interface period_framer_if
    import framer_pkg::*;
#(
    parameter int CNT_W = FRAMER_CNT_W
) ();

    logic             zc_sig;
    logic             cmp1_sig;
    logic             set;
    logic             cmp1_pulse;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             no_signal;
    framer_state_e    state_dbg;

    modport master (
        output zc_sig,
        output cmp1_sig,
        input  set,
        input  cmp1_pulse,
        input  phase_cnt,
        input  period,
        input  locked,
        input  no_signal,
        input  state_dbg
    );

    modport slave (
        input  zc_sig,
        input  cmp1_sig,
        output set,
        output cmp1_pulse,
        output phase_cnt,
        output period,
        output locked,
        output no_signal,
        output state_dbg
    );

endinterface

// File: rtl/period_framer_sig_conditioner.sv
// Conditions one asynchronous comparator output: synchronizer chain,
// run-length glitch filter and rising-edge detector. The rise output is
// combinational from the filter registers so the parent can register its
// strobe in the following cycle.
module sig_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // Run counter only needs to reach FILT_LEN-1; the FILT_LEN-th
    // differing sample is the one that flips the filtered level.
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CW-1:0]          run_q;
    logic                   filt_q;
    logic                   filt_d1_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Metastability chain: bit 0 samples the pin, last bit feeds the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Glitch filter: count consecutive samples differing from the held level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_out == filt_q) begin
            run_q <= '0;
        end else if (run_q == RUN_LAST) begin
            filt_q <= sync_out;
            run_q  <= '0;
        end else begin
            run_q <= run_q + CW'(1);
        end
    end

    // Delayed copy of the filtered level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d1_q <= 1'b0;
        end else begin
            filt_d1_q <= filt_q;
        end
    end

    assign rise = filt_q & ~filt_d1_q;

endmodule

// File: rtl/period_framer.sv
// Period framer: conditions zc and cmp1, measures the zc period, emits a
// one-cycle set at each accepted period start and forwards at most one
// qualified cmp1 pulse per period while locked.
module period_framer
    import framer_pkg::*;
#(
    parameter int SYNC_STAGES = FRAMER_SYNC_STAGES,
    parameter int FILT_LEN    = FRAMER_FILT_LEN,
    parameter int CNT_W       = FRAMER_CNT_W,
    parameter int PER_MIN     = FRAMER_PER_MIN,
    parameter int PER_MAX     = FRAMER_PER_MAX,
    parameter int LOCK_N      = FRAMER_LOCK_N
) (
    input  logic            clk,
    input  logic            rst_n,
    period_framer_if.slave  bus
);

    localparam logic [CNT_W-1:0] PER_MIN_C = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] PER_MAX_C = CNT_W'(PER_MAX);
    localparam int               GOOD_W    = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;
    localparam logic [GOOD_W-1:0] LOCK_N_C = GOOD_W'(LOCK_N);

    logic zc_rise;
    logic cmp1_rise;

    framer_state_e     state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] phase_inc;
    logic             set_q, set_d;
    logic             pulse_q, pulse_d;
    logic             seen_q, seen_d;

    logic lost;
    logic idle_eff;
    logic accept;
    logic locked_now;

    sig_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_zc_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(bus.zc_sig),
        .rise    (zc_rise)
    );

    sig_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_cmp1_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(bus.cmp1_sig),
        .rise    (cmp1_rise)
    );

    // Event qualification. phase_inc is the elapsed count this cycle would
    // reach, so a rise exactly N cycles after the previous one measures N.
    // A rise landing in the loss cycle is treated as a fresh start from IDLE.
    always_comb begin
        phase_inc  = (phase_q >= PER_MAX_C) ? PER_MAX_C : phase_q + CNT_W'(1);
        lost       = (state_q != ST_IDLE) && (phase_q >= PER_MAX_C);
        idle_eff   = (state_q == ST_IDLE) || lost;
        accept     = zc_rise && (idle_eff || (phase_inc >= PER_MIN_C));
        locked_now = (state_q == ST_LOCKED) && !lost;
    end

    // Lock FSM next state and good-period count.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (accept && idle_eff) begin
            state_d = ST_ARMING;
            good_d  = '0;
        end else if (lost) begin
            state_d = ST_IDLE;
            good_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMING: begin
                    if (good_q >= LOCK_N_C) begin
                        state_d = ST_LOCKED;
                    end else if (accept) begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Datapath next values: phase counter, period capture, strobes and the
    // once-per-period cmp1 gate. A cmp1 rise coincident with an accepted zc
    // rise belongs to the new period, so it passes even if the old period
    // already consumed its pulse, and it marks the new period as seen.
    always_comb begin
        set_d    = accept;
        pulse_d  = cmp1_rise && locked_now && (accept || !seen_q);
        phase_d  = phase_inc;
        period_d = period_q;
        seen_d   = seen_q | pulse_d;
        if (accept) begin
            phase_d = '0;
            seen_d  = pulse_d;
            if (!idle_eff) begin
                period_d = phase_inc;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            period_q <= '0;
            set_q    <= 1'b0;
            pulse_q  <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            period_q <= period_d;
            set_q    <= set_d;
            pulse_q  <= pulse_d;
            seen_q   <= seen_d;
        end
    end

    assign bus.set        = set_q;
    assign bus.cmp1_pulse = pulse_q;
    assign bus.phase_cnt  = phase_q;
    assign bus.period     = period_q;
    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.no_signal  = (state_q == ST_IDLE);
    assign bus.state_dbg  = state_q;

endmodule
